// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue between the CPU fetch port and instruction memory.
// Streams sequential words ahead of the fetch address into a DEPTH-entry FIFO;
// a non-sequential fetch or a flush discards the queue and restarts streaming.
module instruction_prefetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] cpu_address,
   input  logic        cpu_read,
   output logic [31:0] cpu_readdata,
   output logic        cpu_waitrequest,
   output logic [31:0] mem_address,
   output logic        mem_read,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [31:0]   head_addr_q, head_addr_d;
   logic [31:0]   fetch_addr_q, fetch_addr_d;
   logic [31:0]   drain_addr_q, drain_addr_d;   // address of the read being drained
   logic          drain_idle_q, drain_idle_d;   // drain was caused by flush -> IDLE after
   logic [31:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic [31:0]   queue_q [DEPTH];

   logic        at_head, hit, pend, miss, accept, stall, push;
   logic [31:0] req_word;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^cpu_address[1:0];
   assign req_word        = {cpu_address[31:2], 2'b00};
   assign at_head         = (cpu_address[31:2] == head_addr_q[31:2]);

   // Hit is served the same cycle; flush and reset both refuse it.
   assign hit  = !rst && !flush && cpu_read && (count_q != '0) && at_head && (state_q != DRAIN);
   // Empty queue already streaming toward the requested word: just wait.
   assign pend = (state_q == STREAM) && (count_q == '0) && at_head;
   // Restart request; in DRAIN the restart is already recorded.
   assign miss = !rst && !flush && cpu_read && !hit && !pend && (state_q != DRAIN);

   // Memory read request derived from registered state (plus the pop that frees a slot).
   always_comb begin
      mem_read = 1'b0;
      if (!rst) begin
         case (state_q)
            STREAM:  mem_read = (count_q < CW'(DEPTH)) || hit;
            DRAIN:   mem_read = 1'b1;
            default: mem_read = 1'b0;
         endcase
      end
   end

   assign mem_address     = (state_q == DRAIN) ? drain_addr_q : fetch_addr_q;
   assign accept          = mem_read && !mem_waitrequest;
   assign stall           = mem_read && mem_waitrequest;
   assign push            = (state_q == STREAM) && accept && !flush && !miss;

   assign cpu_waitrequest = cpu_read && !hit;
   assign cpu_readdata    = (count_q != '0) ? queue_q[rd_ptr_q] : '0;
   assign hit_count       = hit_cnt_q;
   assign miss_count      = miss_cnt_q;

   // Next-state: flush first, then drain completion, restart, and normal streaming.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      head_addr_d  = head_addr_q;
      fetch_addr_d = fetch_addr_q;
      drain_addr_d = drain_addr_q;
      drain_idle_d = drain_idle_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         if (stall) begin
            state_d      = DRAIN;
            drain_addr_d = mem_address;
            drain_idle_d = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end else if (state_q == DRAIN) begin
         if (!mem_waitrequest) state_d = drain_idle_q ? IDLE : STREAM;
      end else if (miss) begin
         count_d      = '0;
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         head_addr_d  = req_word;
         fetch_addr_d = req_word;
         miss_cnt_d   = miss_cnt_q + 32'd1;
         if (stall) begin
            state_d      = DRAIN;
            drain_addr_d = mem_address;
            drain_idle_d = 1'b0;
         end else begin
            state_d = STREAM;
         end
      end else if (state_q == STREAM) begin
         if (push) begin
            wr_ptr_d     = wr_ptr_q + PW'(1);
            fetch_addr_d = fetch_addr_q + 32'd4;
         end
         if (hit) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            head_addr_d = head_addr_q + 32'd4;
            hit_cnt_d   = hit_cnt_q + 32'd1;
         end
         count_d = count_q + CW'(push) - CW'(hit);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         head_addr_q  <= '0;
         fetch_addr_q <= '0;
         drain_addr_q <= '0;
         drain_idle_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         head_addr_q  <= head_addr_d;
         fetch_addr_q <= fetch_addr_d;
         drain_addr_q <= drain_addr_d;
         drain_idle_q <= drain_idle_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   // Queue storage; contents are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) queue_q[wr_ptr_q] <= mem_readdata;
   end
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Testbench for instruction_prefetch_queue: directed scenarios then randomized
// fetch traffic checked against a transaction-level model (memory word = addr+0x100).
module tb_instruction_prefetch_queue;
   logic        clk = 1'b0;
   logic        rst, flush, cpu_read, mem_waitrequest;
   logic [31:0] cpu_address, cpu_readdata, mem_address, mem_readdata;
   logic        cpu_waitrequest, mem_read;
   logic [31:0] hit_count, miss_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Memory contents: word at byte address a holds a + 0x100.
   assign mem_readdata = mem_address + 32'h100;

   instruction_prefetch_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .cpu_address(cpu_address), .cpu_read(cpu_read),
      .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
      .mem_address(mem_address), .mem_read(mem_read),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // Log of every accepted memory read address.
   logic [31:0] acc_q[$];
   int          acc_n = 0;
   always @(posedge clk) begin
      if (!rst && mem_read && !mem_waitrequest) begin
         acc_q.push_back(mem_address);
         acc_n++;
      end
   end

   // A stalled memory read must be held with the same address on the next cycle.
   logic        hold_prev = 1'b0;
   logic [31:0] hold_addr = '0;
   always @(negedge clk) begin
      if (hold_prev && !rst) begin
         n_tests++;
         assert (mem_read === 1'b1 && mem_address === hold_addr) else begin
            n_fail++;
            $error("FAIL hold_rule: observed mem_read=%b addr=%h expected mem_read=1 addr=%h",
                   mem_read, mem_address, hold_addr);
         end
      end
      hold_prev = mem_read && mem_waitrequest && !rst;
      hold_addr = mem_address;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Hold the current request until served; returns at the serving cycle's negedge.
   task automatic wait_done(input string tag, input int budget, input bit rnd,
                            output int waits, output logic [31:0] data);
      waits = 0;
      @(negedge clk);
      while (cpu_waitrequest === 1'b1 && waits < budget) begin
         @(posedge clk);
         #1;
         if (rnd) mem_waitrequest = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         waits++;
      end
      chkb({tag, "_served"}, cpu_waitrequest, 1'b0);
      data = cpu_readdata;
   endtask

   initial begin
      int          w, base, exp_hit, exp_miss, gap;
      logic [31:0] d, addr, last;
      bit          flushed;

      rst = 1'b1; flush = 1'b0; cpu_read = 1'b1; cpu_address = '0; mem_waitrequest = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chkb("rst_cpu_wait", cpu_waitrequest, 1'b1);
      chkb("rst_mem_read", mem_read, 1'b0);
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);
      chk("rst_rdata", cpu_readdata, 32'd0);

      // T1: cold read at 0 then three sequential reads with no waits.
      nxt(); rst = 1'b0;
      @(negedge clk);
      chkb("t1_miss_wait", cpu_waitrequest, 1'b1);
      chkb("t1_idle_mem_read", mem_read, 1'b0);
      nxt(); @(negedge clk);
      chkb("t1_pend_wait", cpu_waitrequest, 1'b1);
      chkb("t1_fetch_read", mem_read, 1'b1);
      chk("t1_fetch_addr", mem_address, 32'h0);
      nxt(); @(negedge clk);
      chkb("t1_first_wait", cpu_waitrequest, 1'b0);
      chk("t1_first_data", cpu_readdata, 32'h100);
      chk("t1_miss_cnt", miss_count, 32'd1);
      for (int i = 1; i < 4; i++) begin
         nxt(); cpu_address = 32'(i * 4);
         @(negedge clk);
         chkb("t1_seq_wait", cpu_waitrequest, 1'b0);
         chk("t1_seq_data", cpu_readdata, 32'(i * 4 + 32'h100));
      end
      nxt(); cpu_read = 1'b0;
      @(negedge clk);
      // The first word, served once the queue refilled, counts as a hit too.
      chk("t1_hits", hit_count, 32'd4);
      chk("t1_misses", miss_count, 32'd1);

      // T2: fill to DEPTH with the CPU idle; one pop allows exactly one more read.
      nxt(); flush = 1'b1;
      nxt(); flush = 1'b0; cpu_read = 1'b1; cpu_address = 32'h1000; base = acc_n;
      wait_done("t2_first", 20, 1'b0, w, d);
      chk("t2_first_data", d, 32'h1100);
      nxt(); cpu_read = 1'b0;
      repeat (8) nxt();
      @(negedge clk);
      chkb("t2_full_no_read", mem_read, 1'b0);
      chk("t2_accepts", 32'(acc_n - base), 32'd5);
      nxt(); cpu_read = 1'b1; cpu_address = 32'h1004;
      @(negedge clk);
      chkb("t2_hit_wait", cpu_waitrequest, 1'b0);
      chk("t2_hit_data", cpu_readdata, 32'h1104);
      chkb("t2_refill_read", mem_read, 1'b1);
      chk("t2_refill_addr", mem_address, 32'h1014);
      nxt(); cpu_read = 1'b0;
      repeat (3) nxt();
      @(negedge clk);
      chkb("t2_full_again", mem_read, 1'b0);
      chk("t2_accepts_after", 32'(acc_n - base), 32'd6);

      // T3: jump to 0x200 while the read of 0x50 is stalled for 3 cycles.
      nxt(); flush = 1'b1;
      nxt(); flush = 1'b0; cpu_read = 1'b1; cpu_address = 32'h40;
      wait_done("t3_first", 20, 1'b0, w, d);
      chk("t3_first_data", d, 32'h140);
      nxt(); cpu_read = 1'b0;
      for (int k = 0; k < 10 && mem_address !== 32'h50; k++) nxt();
      chk("t3_reach_50", mem_address, 32'h50);
      mem_waitrequest = 1'b1; cpu_read = 1'b1; cpu_address = 32'h200;
      @(negedge clk);
      chkb("t3_jump_wait", cpu_waitrequest, 1'b1);
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin nxt(); mem_waitrequest = 1'b0; end
         else nxt();
         @(negedge clk);
         chkb("t3_drain_read", mem_read, 1'b1);
         chk("t3_drain_addr", mem_address, 32'h50);
         chkb("t3_drain_wait", cpu_waitrequest, 1'b1);
      end
      nxt(); @(negedge clk);
      chk("t3_new_addr", mem_address, 32'h200);
      chk("t3_one_restart", miss_count, 32'd4);
      nxt(); @(negedge clk);
      chkb("t3_hit_wait", cpu_waitrequest, 1'b0);
      chk("t3_hit_data", cpu_readdata, 32'h300);

      // T4: flush in the same cycle as a hit.
      nxt(); cpu_address = 32'h204; flush = 1'b1;
      @(negedge clk);
      chkb("t4_refused", cpu_waitrequest, 1'b1);
      nxt(); flush = 1'b0;
      @(negedge clk);
      chk("t4_hits_unchanged", hit_count, 32'd8);
      nxt();
      wait_done("t4_reread", 20, 1'b0, w, d);
      chk("t4_reread_data", d, 32'h304);
      chk("t4_is_miss", miss_count, 32'd5);

      // T5: streaming across the top of the address space.
      nxt(); cpu_read = 1'b0; flush = 1'b1;
      nxt(); flush = 1'b0; cpu_read = 1'b1; cpu_address = 32'hFFFF_FFF8; base = acc_n;
      wait_done("t5_first", 20, 1'b0, w, d);
      chk("t5_first_data", d, 32'h0000_00F8);
      addr = 32'hFFFF_FFF8;
      for (int i = 0; i < 3; i++) begin
         addr = addr + 32'd4;
         nxt(); cpu_address = addr;
         @(negedge clk);
         chkb("t5_seq_wait", cpu_waitrequest, 1'b0);
         chk("t5_seq_data", cpu_readdata, addr + 32'h100);
      end
      chkb("t5_enough_fetches", acc_q.size() >= base + 3, 1'b1);
      if (acc_q.size() >= base + 3) begin
         chk("t5_fetch0", acc_q[base], 32'hFFFF_FFF8);
         chk("t5_fetch1", acc_q[base+1], 32'hFFFF_FFFC);
         chk("t5_fetch2", acc_q[base+2], 32'h0000_0000);
      end

      // T6: reset while a memory read is stalled.
      nxt(); cpu_read = 1'b0; mem_waitrequest = 1'b1;
      @(negedge clk);
      chk("t6_hits_before", hit_count, 32'd13);
      chk("t6_misses_before", miss_count, 32'd6);
      chkb("t6_stalled_read", mem_read, 1'b1);
      nxt(); rst = 1'b1;
      @(negedge clk);
      chkb("t6_rst_no_read", mem_read, 1'b0);
      nxt(); rst = 1'b0;
      @(negedge clk);
      chkb("t6_idle_no_read", mem_read, 1'b0);
      chk("t6_hits_zero", hit_count, 32'd0);
      chk("t6_misses_zero", miss_count, 32'd0);
      chk("t6_rdata_zero", cpu_readdata, 32'd0);
      nxt(); mem_waitrequest = 1'b0; cpu_read = 1'b1; cpu_address = 32'h2000;
      wait_done("t6_read", 20, 1'b0, w, d);
      chk("t6_read_data", d, 32'h2100);
      chk("t6_read_waits", 32'(w), 32'd2);

      // Random traffic: mostly sequential, some jumps (incl. near wrap), flushes
      // between requests, random memory wait states.
      exp_hit = 1; exp_miss = 1; last = 32'h2000; flushed = 1'b0;
      for (int r = 0; r < 300; r++) begin
         nxt(); cpu_read = 1'b0;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            mem_waitrequest = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            if (flush) flushed = 1'b1;
            nxt();
         end
         flush = 1'b0;
         case ($urandom_range(0, 7))
            5:       addr = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            6, 7:    addr = $urandom & 32'hFFFF_FFFC;
            default: addr = last + 32'd4;
         endcase
         if (flushed || addr != last + 32'd4) exp_miss++;
         cpu_address = addr | 32'($urandom_range(0, 3));
         cpu_read = 1'b1;
         mem_waitrequest = ($urandom_range(0, 3) == 0);
         wait_done("rnd", 60, 1'b1, w, d);
         chk("rnd_data", d, addr + 32'h100);
         exp_hit++;
         last = addr;
         flushed = 1'b0;
      end
      nxt(); cpu_read = 1'b0;
      @(negedge clk);
      chk("rnd_hits", hit_count, 32'(exp_hit));
      chk("rnd_misses", miss_count, 32'(exp_miss));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
